// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pkg
// Description : Shared framing-mode, FSM-state and bit-counter definitions
//               for the I2S stereo receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    localparam int MODE_I2S = 0;
    localparam int MODE_LJ  = 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam int         CNT_W   = 6;
    localparam logic [5:0] CNT_MAX = 6'd63;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 6'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_rx_stereo_if.sv
`default_nettype none
// ============================================================================
// Module      : i2s_rx_stereo_if
// Description : Show-ahead stereo-pair stream between receiver and consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2s_rx_stereo_if #(
    parameter int DATA_W = 16
);
    logic                     m_valid;
    logic                     m_ready;
    logic signed [DATA_W-1:0] m_left;
    logic signed [DATA_W-1:0] m_right;

    modport master (
        output m_valid,
        output m_left,
        output m_right,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_left,
        input  m_right,
        output m_ready
    );
endinterface
`default_nettype wire

// File: rtl/i2s_pair_fifo.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pair_fifo
// Description : Synchronous show-ahead FIFO; a push into a full FIFO is taken
//               only when a pop happens on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_pair_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  wire                      clk,
    input  wire                      rst_n,
    input  wire                      push,
    input  wire                      pop,
    input  wire  [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int                c_AW      = $clog2(DEPTH);
    localparam int                c_LW      = c_AW + 1;
    localparam logic [c_AW-1:0]   c_PTR_ONE = c_AW'(1);
    localparam logic [c_LW-1:0]   c_LVL_ONE = c_LW'(1);
    localparam logic [c_LW-1:0]   c_FULL    = c_LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_LW-1:0]  r_level;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_level == '0);
    assign full      = (r_level == c_FULL);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign level     = r_level;
    // Head reads as zero while empty so the outputs match their reset value.
    assign rdata     = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_rx_stereo.sv
`default_nettype none
// ============================================================================
// Module      : i2s_rx_stereo
// Description : I2S / left-justified stereo receiver with a pair FIFO and
//               sticky overrun / frame-error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx_stereo
    import i2s_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int MODE       = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  wire                            bclk,
    input  wire                            rst_n,
    input  wire                            en,
    input  wire                            lrclk,
    input  wire                            adcdat,
    input  wire                            clr_err,
    i2s_rx_stereo_if.master                m_if,
    output logic [$clog2(FIFO_DEPTH):0]    level,
    output logic                           overrun,
    output logic                           frame_err
);

    localparam int               c_D    = (MODE == MODE_I2S) ? 1 : 0;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(c_D + DATA_W - 1);

    logic                r_lrclk_d;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_sr_left;
    logic [DATA_W-1:0]   r_sr_right;
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_left_ok;

    logic                w_edge;
    logic                w_fall;
    logic                w_rise;
    logic [CNT_W-1:0]    w_pos;
    logic                w_in_word;
    logic                w_slot_full;
    logic                w_frame_end;
    logic                w_push;
    logic                w_frame_bad;
    logic                w_full;
    logic                w_empty;
    logic                w_overrun_set;
    logic [2*DATA_W-1:0] w_head;

    assign w_edge      = (lrclk != r_lrclk_d);
    assign w_fall      = w_edge && !lrclk;
    assign w_rise      = w_edge && lrclk;
    assign w_pos       = w_edge ? '0 : sat_inc(r_cnt);
    assign w_in_word   = (w_pos <= c_LAST) && ((c_D == 0) || (w_pos != '0));
    // r_cnt holds the last slot position, so the slot length is r_cnt + 1.
    assign w_slot_full = (r_cnt >= c_LAST);

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            r_lrclk_d  <= 1'b1;
            r_cnt      <= '0;
            r_sr_left  <= '0;
            r_sr_right <= '0;
        end else begin
            r_lrclk_d <= lrclk;
            r_cnt     <= w_pos;
            if (w_in_word) begin
                if (lrclk) begin
                    r_sr_right <= {r_sr_right[DATA_W-2:0], adcdat};
                end else begin
                    r_sr_left  <= {r_sr_left[DATA_W-2:0], adcdat};
                end
            end
        end
    end

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_SYNC;
                ST_SYNC: if (w_fall) w_state_nxt = ST_RUN;
                ST_RUN:  w_state_nxt = ST_RUN;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_frame_end = 1'b0;
        w_push      = 1'b0;
        w_frame_bad = 1'b0;
        if ((r_state == ST_RUN) && en && w_fall) begin
            w_frame_end = 1'b1;
        end
        w_push      = w_frame_end && r_left_ok && w_slot_full;
        w_frame_bad = w_frame_end && !(r_left_ok && w_slot_full);
    end

    // Left-slot completeness is latched at the rising lrclk edge that ends it.
    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            r_left_ok <= 1'b0;
        end else if (r_state != ST_RUN) begin
            r_left_ok <= 1'b0;
        end else if (en && w_rise) begin
            r_left_ok <= w_slot_full;
        end
    end

    i2s_pair_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (bclk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (m_if.m_ready),
        .wdata ({r_sr_left, r_sr_right}),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );

    assign m_if.m_valid = !w_empty;
    assign m_if.m_left  = w_head[2*DATA_W-1:DATA_W];
    assign m_if.m_right = w_head[DATA_W-1:0];

    assign w_overrun_set = w_push && w_full && !(m_if.m_ready && !w_empty);

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (w_overrun_set) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (w_frame_bad) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
